// File: rtl/easyaxi_ar_arb.sv
// easyaxi_ar_arb: round-robin arbiter sharing one AXI read channel, ARID index prefix, R routed back by prefix.
// Define EASYAXI_AR_OST_LIMIT_EN to cap outstanding bursts per master at MAX_OST.
module easyaxi_ar_arb #(
    parameter int NUM_MST = 4,
    parameter int ID_W    = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int MAX_OST = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               enable,
    input  logic [NUM_MST-1:0]                 m_arvalid,
    output logic [NUM_MST-1:0]                 m_arready,
    input  logic [NUM_MST*ID_W-1:0]            m_arid,
    input  logic [NUM_MST*ADDR_W-1:0]          m_araddr,
    input  logic [NUM_MST*8-1:0]               m_arlen,
    output logic                               s_arvalid,
    input  logic                               s_arready,
    output logic [ID_W+$clog2(NUM_MST)-1:0]    s_arid,
    output logic [ADDR_W-1:0]                  s_araddr,
    output logic [7:0]                         s_arlen,
    input  logic                               s_rvalid,
    output logic                               s_rready,
    input  logic [ID_W+$clog2(NUM_MST)-1:0]    s_rid,
    input  logic [DATA_W-1:0]                  s_rdata,
    input  logic                               s_rlast,
    output logic [NUM_MST-1:0]                 m_rvalid,
    input  logic [NUM_MST-1:0]                 m_rready,
    output logic [NUM_MST*ID_W-1:0]            m_rid,
    output logic [NUM_MST*DATA_W-1:0]          m_rdata,
    output logic [NUM_MST-1:0]                 m_rlast
);
    localparam int IDX_W = $clog2(NUM_MST);
    localparam int SID_W = ID_W + IDX_W;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]         state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   gnt;
    logic [NUM_MST-1:0] eligible;
    logic               grant_go;
    logic [IDX_W-1:0]   r_idx;
    logic               r_hit;

    assign r_idx = s_rid[SID_W-1:ID_W];
    assign r_hit = int'(r_idx) < NUM_MST;

`ifdef EASYAXI_AR_OST_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_OST + 1);
    logic [CNT_W-1:0] ost [NUM_MST];
    for (genvar i = 0; i < NUM_MST; i++) begin : g_ost
        logic inc, dec;
        assign inc = grant_go && gnt == IDX_W'(i);
        assign dec = s_rvalid && s_rready && s_rlast && r_hit && r_idx == IDX_W'(i);
        assign eligible[i] = m_arvalid[i] && ost[i] != CNT_W'(MAX_OST);
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) ost[i] <= '0;
            else if (inc != dec) ost[i] <= inc ? ost[i] + 1'b1 : ost[i] - 1'b1;
    end
`else
    assign eligible = m_arvalid;
`endif

    // Scan from farthest to nearest so the first eligible after ptr wins.
    always_comb begin
        gnt = '0;
        for (int k = NUM_MST; k >= 1; k--)
            if (eligible[(int'(ptr) + k) % NUM_MST]) gnt = IDX_W'((int'(ptr) + k) % NUM_MST);
    end

    assign grant_go  = rst_n && state == ST_IDLE && enable && |eligible;
    assign m_arready = grant_go ? NUM_MST'(1) << gnt : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= IDX_W'(NUM_MST - 1);
            s_arvalid <= 1'b0;
            s_arid    <= '0;
            s_araddr  <= '0;
            s_arlen   <= '0;
        end else if (grant_go) begin
            state     <= ST_BUSY;
            ptr       <= gnt;
            s_arvalid <= 1'b1;
            s_arid    <= {gnt, m_arid[gnt*ID_W +: ID_W]};
            s_araddr  <= m_araddr[gnt*ADDR_W +: ADDR_W];
            s_arlen   <= m_arlen[gnt*8 +: 8];
        end else if (state == ST_BUSY && s_arready) begin
            state     <= ST_IDLE;
            s_arvalid <= 1'b0;
        end
    end

    // Beats whose prefix names no master are accepted and discarded.
    assign m_rvalid = (s_rvalid && r_hit) ? NUM_MST'(1) << r_idx : '0;
    assign s_rready = r_hit ? m_rready[r_idx] : 1'b1;
    assign m_rid    = {NUM_MST{s_rid[ID_W-1:0]}};
    assign m_rdata  = {NUM_MST{s_rdata}};
    assign m_rlast  = {NUM_MST{s_rlast}};
endmodule

// File: tb/tb_easyaxi_ar_arb.sv
// tb_easyaxi_ar_arb: directed and random checks of easyaxi_ar_arb against a cycle model.
// The EASYAXI_AR_OST_LIMIT_EN section runs only when the macro is defined.
module tb_easyaxi_ar_arb;
    localparam int N = 4, IW = 4, AW = 32, DW = 64, MO = 4, SW = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              enable = 1'b0;
    logic [N-1:0]      m_arvalid = '0, m_arready;
    logic [N*IW-1:0]   m_arid = '0;
    logic [N*AW-1:0]   m_araddr = '0;
    logic [N*8-1:0]    m_arlen = '0;
    logic              s_arvalid, s_arready = 1'b0;
    logic [SW-1:0]     s_arid;
    logic [AW-1:0]     s_araddr;
    logic [7:0]        s_arlen;
    logic              s_rvalid = 1'b0, s_rready, s_rlast = 1'b0;
    logic [SW-1:0]     s_rid = '0;
    logic [DW-1:0]     s_rdata = '0;
    logic [N-1:0]      m_rvalid, m_rready = '0, m_rlast;
    logic [N*IW-1:0]   m_rid;
    logic [N*DW-1:0]   m_rdata;

    easyaxi_ar_arb dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid),
        .m_araddr(m_araddr), .m_arlen(m_arlen),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid),
        .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid),
        .s_rdata(s_rdata), .s_rlast(s_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid),
        .m_rdata(m_rdata), .m_rlast(m_rlast)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    bit            md_busy;
    int            md_last;
    logic [SW-1:0] md_id;
    logic [AW-1:0] md_addr;
    logic [7:0]    md_len;
    int            md_ost [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic bit may_issue(int c);
`ifdef EASYAXI_AR_OST_LIMIT_EN
        return md_ost[c] < MO;
`else
        return 1'b1;
`endif
    endfunction

    function automatic int pick();
        if (md_busy || !enable) return -1;
        for (int k = 1; k <= N; k++)
            if (m_arvalid[(md_last + k) % N] && may_issue((md_last + k) % N)) return (md_last + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        md_busy = 0; md_last = N - 1; md_id = '0; md_addr = '0; md_len = '0;
        for (int i = 0; i < N; i++) md_ost[i] = 0;
    endtask

    // Called just after a falling edge with inputs set; checks, then advances one cycle.
    task automatic tick();
        int w, ri;
        #1;
        w  = pick();
        ri = int'(s_rid[SW-1:IW]);
        chk("m_arready", 64'(m_arready), w >= 0 ? 64'(1) << w : 64'd0);
        chk("s_arvalid", 64'(s_arvalid), 64'(md_busy));
        chk("s_arid", 64'(s_arid), 64'(md_id));
        chk("s_araddr", 64'(s_araddr), 64'(md_addr));
        chk("s_arlen", 64'(s_arlen), 64'(md_len));
        chk("m_rvalid", 64'(m_rvalid), s_rvalid ? 64'(1) << ri : 64'd0);
        chk("s_rready", 64'(s_rready), 64'(m_rready[ri]));
        chk("m_rid", 64'(m_rid), 64'({N{s_rid[IW-1:0]}}));
        chk("m_rlast", 64'(m_rlast), 64'({N{s_rlast}}));
        chk("m_rdata", m_rdata[ri*DW +: DW], s_rdata);
        @(posedge clk);
        if (w >= 0) begin
            md_busy = 1; md_last = w;
            md_id   = {2'(w), m_arid[w*IW +: IW]};
            md_addr = m_araddr[w*AW +: AW];
            md_len  = m_arlen[w*8 +: 8];
            md_ost[w]++;
        end else if (md_busy && s_arready) md_busy = 0;
        if (s_rvalid && m_rready[ri] && s_rlast) md_ost[ri]--;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_s_arvalid", 64'(s_arvalid), 64'd0);
        chk("rst_m_arready", 64'(m_arready), 64'd0);
        chk("rst_s_arid", 64'(s_arid), 64'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic randomize_inputs();
        int ri;
        enable    = $urandom_range(0, 7) != 0;
        m_arvalid = N'($urandom);
        m_arid    = (N*IW)'($urandom);
        m_araddr  = {$urandom, $urandom, $urandom, $urandom};
        m_arlen   = $urandom;
        s_arready = $urandom_range(0, 2) != 0;
        s_rvalid  = 1'($urandom);
        s_rid     = SW'($urandom);
        s_rdata   = {$urandom, $urandom};
        m_rready  = N'($urandom);
        ri        = int'(s_rid[SW-1:IW]);
        s_rlast   = 1'($urandom) && md_ost[ri] > 0;
    endtask

    initial begin
        int n;
        model_reset();
        do_reset();
        tick();

        enable = 1; m_arvalid = 4'hF; s_arready = 1;
        m_arid = 16'h4321; m_araddr = {32'h400, 32'h300, 32'h200, 32'h100}; m_arlen = 32'h04030201;
        n = 0;
        repeat (10) begin
            if (s_arvalid) begin
                chk("rr_order", 64'(s_arid[5:4]), 64'(n % 4));
                n++;
            end
            tick();
        end
        chk("rr_count", 64'(n), 64'd5);
        tick();
        do_reset();
        #1 chk("first_after_rst", 64'(m_arready), 64'd1);
        tick();
        m_arvalid = 0;
        tick();

        m_arvalid = 4'b0100; s_arready = 0;
        m_arid = 16'h0500; m_araddr = '0; m_araddr[95:64] = 32'h1000; m_arlen = '0; m_arlen[23:16] = 8'd3;
        tick();
        m_arvalid = 0; m_arid = '1; m_araddr = '1; m_arlen = '1;
        repeat (5) begin
            chk("hold_arid", 64'(s_arid), 64'h25);
            chk("hold_araddr", 64'(s_araddr), 64'h1000);
            chk("hold_arlen", 64'(s_arlen), 64'd3);
            tick();
        end
        s_arready = 1;
        tick();

        enable = 0; m_arvalid = 4'hF;
        repeat (3) begin
            #1 chk("en_off", 64'(m_arready), 64'd0);
            tick();
        end
        enable = 1; s_arready = 0;
        tick();
        enable = 0;
        tick();
        s_arready = 1;
        tick();
        chk("en_off_done", 64'(s_arvalid), 64'd0);
        m_arvalid = 0;

        s_rvalid = 1; s_rid = 6'h25;
        for (int b = 0; b < 4; b++) begin
            s_rlast = b == 3; m_rready = N'(b % 2 ? 4'b0100 : 4'b1011); s_rdata = {$urandom, $urandom};
            #1 chk("r_route", 64'(m_rvalid), 64'h4);
            chk("r_ready", 64'(s_rready), 64'(m_rready[2]));
            tick();
        end
        s_rvalid = 0; s_rlast = 0;
        tick();

`ifdef EASYAXI_AR_OST_LIMIT_EN
        do_reset();
        enable = 1; s_arready = 1; m_arvalid = 4'b0010;
        repeat (8) tick();
        m_arvalid = 4'b0011;
        #1 chk("ost_block", 64'(m_arready), 64'h1);
        tick();
        m_arvalid = 4'b0010;
        tick();
        #1 chk("ost_still_blocked", 64'(m_arready), 64'h0);
        s_rvalid = 1; s_rid = 6'h10; s_rlast = 1; m_rready = 4'b0010;
        tick();
        s_rvalid = 0; s_rlast = 0;
        #1 chk("ost_release", 64'(m_arready), 64'h2);
        tick();
        tick();
`endif

        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            randomize_inputs();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
